// File: rtl/mips16_pkg.sv
// Shared definitions for the mips_16 program loader: state encoding and data widths.
package mips16_pkg;

  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_CSUM    = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } loader_state_e;

endpackage

// File: rtl/mips16_loader_csum.sv
// 8-bit modular byte accumulator; zero reports whether the sum including the
// byte currently offered on add_data wraps to 0x00. Built only with MIPS16_LOADER_CSUM_EN.
`ifdef MIPS16_LOADER_CSUM_EN
module mips16_loader_csum
  import mips16_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [BYTE_W-1:0] add_data,
  output logic              zero
);

  logic [BYTE_W-1:0] acc;
  logic [BYTE_W-1:0] acc_next;

  assign acc_next = acc + add_data;
  assign zero     = (acc_next == '0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc_next;
    end
  end

endmodule
`endif

// File: rtl/mips16_prog_loader.sv
// Byte-stream program loader for the mips_16 instruction memory; holds the core
// in reset until an image is written. MIPS16_LOADER_CSUM_EN adds the trailing checksum byte.
module mips16_prog_loader
  import mips16_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic               reload,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [15:0]        imem_wdata,
  output logic               core_reset,
  output logic               done,
  output logic               error
);

  localparam int IDX_W = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, so the source may hold in_valid freely.
`ifdef MIPS16_LOADER_CSUM_EN
  localparam loader_state_e TAIL_STATE = ST_CSUM;
`else
  localparam loader_state_e TAIL_STATE = ST_DONE;
`endif

  loader_state_e     state, state_next;
  logic [BYTE_W-1:0] len_hi_q;
  logic [BYTE_W-1:0] hi_q;
  logic [IDX_W-1:0]  len_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_inc;
  logic [16:0]       len_full;
  logic              hs;
  logic              restart;
  logic              csum_ok;

  assign hs       = in_valid && in_ready;
  assign restart  = reload && ((state == ST_DONE) || (state == ST_ERR));
  assign len_full = {1'b0, len_hi_q, in_data};
  assign idx_inc  = idx_q + 1'b1;

`ifdef MIPS16_LOADER_CSUM_EN
  mips16_loader_csum u_csum (
    .clk      (clk),
    .reset    (reset),
    .clear    (restart),
    .add_en   (hs),
    .add_data (in_data),
    .zero     (csum_ok)
  );
`else
  assign csum_ok = 1'b0;
`endif

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    core_reset = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      ST_LEN_HI: begin
        in_ready = 1'b1;
        if (hs) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        in_ready = 1'b1;
        if (hs) begin
          if (len_full > MAX_WORDS) state_next = ST_ERR;
          else if (len_full == '0)  state_next = TAIL_STATE;
          else                      state_next = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        in_ready = 1'b1;
        if (hs) state_next = ST_DATA_LO;
      end
      ST_DATA_LO: begin
        in_ready = 1'b1;
        if (hs) state_next = (idx_inc < len_q) ? ST_DATA_HI : TAIL_STATE;
      end
      ST_CSUM: begin
        in_ready = 1'b1;
        if (hs) state_next = csum_ok ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
        if (reload) state_next = ST_LEN_HI;
      end
      ST_ERR: begin
        error = 1'b1;
        if (reload) state_next = ST_LEN_HI;
      end
      default: state_next = ST_LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_LEN_HI;
      len_hi_q   <= '0;
      hi_q       <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state   <= state_next;
      imem_we <= 1'b0;
      if (hs) begin
        case (state)
          ST_LEN_HI:  len_hi_q <= in_data;
          ST_LEN_LO: begin
            len_q <= len_full[IDX_W-1:0];
            idx_q <= '0;
          end
          ST_DATA_HI: hi_q <= in_data;
          ST_DATA_LO: begin
            imem_we    <= 1'b1;
            imem_addr  <= idx_q[ADDR_W-1:0];
            imem_wdata <= {hi_q, in_data};
            idx_q      <= idx_inc;
          end
          default: ;
        endcase
      end
      if (restart) idx_q <= '0;
    end
  end

endmodule
